// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_D / NREGS_D : default data width and register count
//   AW_D             : address width for the default register count
//   reg_addr_t       : register address type at the default width
//   is_zero_reg()    : true when an address selects the hard-wired zero entry
package regfile_pkg;

  localparam int unsigned XLEN_D  = 32;
  localparam int unsigned NREGS_D = 32;
  localparam int unsigned AW_D    = $clog2(NREGS_D);

  typedef logic [AW_D-1:0] reg_addr_t;

  // Takes a zero-extended address so it serves any parametrised width up to 32 bits.
  function automatic logic is_zero_reg(input logic [31:0] addr);
    return (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a producer
// issues and cleared when its result is written back.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears every bit
//   wr_en     write enable per write port (writeback clears the bit)
//   wr_addr   write addresses, port j at [j*AW +: AW]
//   iss_en    issue strobe, sets the bit of iss_addr
//   iss_addr  destination register of the issued instruction
//   sb_flush  clears every bit (pipeline flush), wins over issue
//   busy_vec  current scoreboard, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_D,
  parameter int unsigned NW    = 1,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             sb_flush,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_d;

  always_comb begin
    w_busy_d = r_busy;
    if (sb_flush) begin
      w_busy_d = '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j]) begin
          w_busy_d[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      // Set after clear: a same-cycle issue means a newer producer is still pending.
      if (iss_en) begin
        w_busy_d[iss_addr] = 1'b1;
      end
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with NR combinational read ports, NW write ports
// and a per-register pending-write scoreboard. Entry 0 reads as zero.
// Optional feature macro: REGFILE_BYPASS_EN enables write-through forwarding from
// the write ports to the read ports in the same cycle.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (data and scoreboard)
//   rd_addr   read addresses, port k at [k*AW +: AW]
//   rd_data   read data, port k at [k*XLEN +: XLEN]
//   rd_busy   scoreboard bit for each read address
//   wr_en     write enable per write port
//   wr_addr   write addresses, port j at [j*AW +: AW]
//   wr_data   write data, port j at [j*XLEN +: XLEN]
//   iss_en    issue strobe, marks iss_addr pending
//   iss_addr  destination register of the issued instruction
//   sb_flush  clear the whole scoreboard
//   busy_vec  full scoreboard vector
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_D,
  parameter int unsigned NREGS = NREGS_D,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 1,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_addr,
  input  logic               sb_flush,
  output logic [NREGS-1:0]   busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy_vec;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NW    (NW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .sb_flush (sb_flush),
    .busy_vec (w_busy_vec)
  );

  assign busy_vec = w_busy_vec;

  // Later ports overwrite earlier ones in loop order, so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && !is_zero_reg(32'(wr_addr[j*AW +: AW]))) begin
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_d;
    logic            w_b;
`ifdef REGFILE_BYPASS_EN
    logic            w_fwd;
`endif
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NR; k++) begin
      w_a = rd_addr[k*AW +: AW];
      w_d = r_regs[w_a];
      w_b = w_busy_vec[w_a];
`ifdef REGFILE_BYPASS_EN
      w_fwd = 1'b0;
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_a)) begin
          w_d   = wr_data[j*XLEN +: XLEN];
          w_fwd = 1'b1;
        end
      end
      // Forwarded data is no longer pending, unless a newer producer issues now.
      if (w_fwd && !(iss_en && (iss_addr == w_a))) begin
        w_b = 1'b0;
      end
`endif
      if (is_zero_reg(32'(w_a))) begin
        w_d = '0;
        w_b = 1'b0;
      end
      rd_data[k*XLEN +: XLEN] = w_d;
      rd_busy[k]              = w_b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NR    = 2;
  localparam int unsigned NW    = 2;
  localparam int unsigned AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*XLEN-1:0] rd_data;
  logic [NR-1:0]      rd_busy;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*XLEN-1:0] wr_data;
  logic               iss_en;
  logic [AW-1:0]      iss_addr;
  logic               sb_flush;
  logic [NREGS-1:0]   busy_vec;

  int total;
  int bad;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NR    (NR),
    .NW    (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .sb_flush (sb_flush),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst      = 1'b0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    sb_flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] got;
    idle();
    wr_en   = 2'b11;
    wr_addr = {5'd5, 5'd3};
    wr_data = {32'hBBBB_0005, 32'hAAAA_0003};
    iss_en  = 1'b1;
    iss_addr = 5'd3;
    tick();
    idle();
    rd_addr = {5'd5, 5'd3};
    #1;
    total++;
    if (rd_data !== {32'hBBBB_0005, 32'hAAAA_0003}) begin
      bad++;
      $display("FAIL reset_precontent: got %h want %h", rd_data, {32'hBBBB_0005, 32'hAAAA_0003});
    end
    rst      = 1'b1;
    iss_en   = 1'b1;
    iss_addr = 5'd8;
    tick();
    idle();
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {5'd0, 5'(a)};
      #1;
      got = rd_data[XLEN-1:0];
      total++;
      if (got !== 32'd0) begin
        bad++;
        $display("FAIL reset_data[%0d]: got %h want 0", a, got);
      end
    end
    total++;
    if (busy_vec !== 32'd0) begin
      bad++;
      $display("FAIL reset_busy: got %h want 0", busy_vec);
    end
  endtask

  task automatic test_write_read();
    logic [XLEN-1:0] exp_same;
    idle();
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'd0, 32'hDEAD_BEEF};
    rd_addr = {5'd5, 5'd0};
    exp_same = BYP ? 32'hDEAD_BEEF : 32'd0;
    #1;
    total++;
    if (rd_data[XLEN +: XLEN] !== exp_same) begin
      bad++;
      $display("FAIL write_same_cycle: got %h want %h", rd_data[XLEN +: XLEN], exp_same);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_data[XLEN +: XLEN] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL write_next_cycle: got %h want deadbeef", rd_data[XLEN +: XLEN]);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd0};
    wr_data  = {32'd0, 32'h0000_1234};
    iss_en   = 1'b1;
    iss_addr = 5'd0;
    rd_addr  = {5'd0, 5'd0};
    #1;
    total++;
    if (rd_data[XLEN-1:0] !== 32'd0 || rd_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL zero_same_cycle: got data %h busy %b want 0 0", rd_data[XLEN-1:0], rd_busy[0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_data[XLEN-1:0] !== 32'd0) begin
      bad++;
      $display("FAIL zero_read: got %h want 0", rd_data[XLEN-1:0]);
    end
    total++;
    if (busy_vec !== 32'd0) begin
      bad++;
      $display("FAIL zero_issue: got %h want 0", busy_vec);
    end
  endtask

  task automatic test_dual_write();
    logic [XLEN-1:0] exp_same;
    idle();
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h0000_0022, 32'h0000_0011};
    rd_addr = {5'd0, 5'd7};
    exp_same = BYP ? 32'h22 : 32'h0;
    #1;
    total++;
    if (rd_data[XLEN-1:0] !== exp_same) begin
      bad++;
      $display("FAIL dual_same_cycle: got %h want %h", rd_data[XLEN-1:0], exp_same);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_data[XLEN-1:0] !== 32'h22) begin
      bad++;
      $display("FAIL dual_write: got %h want 22", rd_data[XLEN-1:0]);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_b;
    idle();
    rd_addr  = {5'd0, 5'd9};
    iss_en   = 1'b1;
    iss_addr = 5'd9;
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1 || busy_vec !== 32'h0000_0200) begin
      bad++;
      $display("FAIL sb_issue: got busy %b vec %h want 1 00000200", rd_busy[0], busy_vec);
    end
    wr_en   = 2'b10;
    wr_addr = {5'd9, 5'd0};
    wr_data = {32'h0000_0099, 32'd0};
    exp_b   = BYP ? 1'b0 : 1'b1;
    #1;
    total++;
    if (rd_busy[0] !== exp_b) begin
      bad++;
      $display("FAIL sb_wb_same_cycle: got %b want %b", rd_busy[0], exp_b);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0 || busy_vec !== 32'd0) begin
      bad++;
      $display("FAIL sb_clear: got busy %b vec %h want 0 0", rd_busy[0], busy_vec);
    end
    iss_en   = 1'b1;
    iss_addr = 5'd9;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd9};
    wr_data  = {32'd0, 32'h0000_0909};
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1 || busy_vec !== 32'h0000_0200) begin
      bad++;
      $display("FAIL sb_issue_and_wb: got busy %b vec %h want 1 00000200", rd_busy[0], busy_vec);
    end
    total++;
    if (rd_data[XLEN-1:0] !== 32'h0000_0909) begin
      bad++;
      $display("FAIL sb_issue_and_wb_data: got %h want 00000909", rd_data[XLEN-1:0]);
    end
  endtask

  task automatic test_flush_and_reset();
    idle();
    iss_en = 1'b1;
    iss_addr = 5'd3;
    tick();
    iss_addr = 5'd12;
    tick();
    idle();
    #1;
    total++;
    if (busy_vec !== 32'h0000_1208) begin
      bad++;
      $display("FAIL flush_setup: got %h want 00001208", busy_vec);
    end
    sb_flush = 1'b1;
    iss_en   = 1'b1;
    iss_addr = 5'd4;
    tick();
    idle();
    #1;
    total++;
    if (busy_vec !== 32'd0) begin
      bad++;
      $display("FAIL flush: got %h want 0", busy_vec);
    end
    rst     = 1'b1;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd20};
    wr_data = {32'd0, 32'hAAAA_5555};
    tick();
    idle();
    rd_addr = {5'd7, 5'd20};
    #1;
    total++;
    if (rd_data[XLEN-1:0] !== 32'd0) begin
      bad++;
      $display("FAIL reset_drops_write: got %h want 0", rd_data[XLEN-1:0]);
    end
    total++;
    if (rd_data[XLEN +: XLEN] !== 32'd0) begin
      bad++;
      $display("FAIL reset_clears_r7: got %h want 0", rd_data[XLEN +: XLEN]);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rd_addr = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_dual_write();
    test_scoreboard();
    test_flush_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
